// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one fixed-latency single-ported memory between instruction fetch and
// load/store. One access in flight at a time; grants alternate when both ports request.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_ready,
  input  logic                dm_req,
  input  logic                dm_we,
  input  logic [ADDR_W-1:0]   dm_addr,
  input  logic [DATA_W-1:0]   dm_wdata,
  input  logic [DATA_W/8-1:0] dm_wstrb,
  output logic [DATA_W-1:0]   dm_rdata,
  output logic                dm_ready,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                stall_if,
  output logic                stall_mem,
  output logic [1:0]          dbg_state
);

  // Handshake: a requester holds req and its operands until it sees its one-cycle ready
  // pulse; the pulse cycle masks that requester's req so it is not granted twice.
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_DONE = 2'd2} state_t;

  localparam int         STRB_W = DATA_W / 8;
  localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

  state_t              r_state, w_state_nxt;
  logic [3:0]          r_cnt, w_cnt_nxt;
  logic                r_last_dm, w_last_dm_nxt;
  logic                r_owner_dm, w_owner_dm_nxt;
  logic                r_mem_en, w_mem_en_nxt;
  logic                r_mem_we, w_mem_we_nxt;
  logic [ADDR_W-1:0]   r_mem_addr, w_mem_addr_nxt;
  logic [DATA_W-1:0]   r_mem_wdata, w_mem_wdata_nxt;
  logic [STRB_W-1:0]   r_mem_wstrb, w_mem_wstrb_nxt;
  logic [DATA_W-1:0]   r_if_rdata, w_if_rdata_nxt;
  logic [DATA_W-1:0]   r_dm_rdata, w_dm_rdata_nxt;
  logic                r_if_ready, w_if_ready_nxt;
  logic                r_dm_ready, w_dm_ready_nxt;
  logic                w_if_pend, w_dm_pend, w_grant_dm;

  // The ready flags are only ever high for the owner in DONE, so they double as the mask.
  assign w_if_pend  = if_req & ~r_if_ready;
  assign w_dm_pend  = dm_req & ~r_dm_ready;
  assign w_grant_dm = w_dm_pend & (~w_if_pend | ~r_last_dm);

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_last_dm_nxt   = r_last_dm;
    w_owner_dm_nxt  = r_owner_dm;
    w_mem_en_nxt    = r_mem_en;
    w_mem_we_nxt    = r_mem_we;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_wdata_nxt = r_mem_wdata;
    w_mem_wstrb_nxt = r_mem_wstrb;
    w_if_rdata_nxt  = r_if_rdata;
    w_dm_rdata_nxt  = r_dm_rdata;
    w_if_ready_nxt  = 1'b0;
    w_dm_ready_nxt  = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (w_if_pend | w_dm_pend) begin
          w_state_nxt     = S_BUSY;
          w_cnt_nxt       = LAT_M1;
          w_owner_dm_nxt  = w_grant_dm;
          w_mem_en_nxt    = 1'b1;
          w_mem_we_nxt    = w_grant_dm & dm_we;
          w_mem_addr_nxt  = w_grant_dm ? dm_addr : if_addr;
          w_mem_wdata_nxt = w_grant_dm ? dm_wdata : '0;
          w_mem_wstrb_nxt = (w_grant_dm & dm_we) ? dm_wstrb : '0;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_BUSY: begin
        if (r_cnt != 4'd0) begin
          w_cnt_nxt = r_cnt - 4'd1;
        end else begin
          w_state_nxt     = S_DONE;
          w_mem_en_nxt    = 1'b0;
          w_mem_we_nxt    = 1'b0;
          w_mem_wstrb_nxt = '0;
          w_last_dm_nxt   = r_owner_dm;
          if (r_owner_dm) begin
            w_dm_ready_nxt = 1'b1;
            if (!r_mem_we) w_dm_rdata_nxt = mem_rdata;
          end else begin
            w_if_ready_nxt = 1'b1;
            w_if_rdata_nxt = mem_rdata;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= 4'd0;
      r_last_dm   <= 1'b0;
      r_owner_dm  <= 1'b0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_wstrb <= '0;
      r_if_rdata  <= '0;
      r_dm_rdata  <= '0;
      r_if_ready  <= 1'b0;
      r_dm_ready  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_last_dm   <= w_last_dm_nxt;
      r_owner_dm  <= w_owner_dm_nxt;
      r_mem_en    <= w_mem_en_nxt;
      r_mem_we    <= w_mem_we_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_wdata <= w_mem_wdata_nxt;
      r_mem_wstrb <= w_mem_wstrb_nxt;
      r_if_rdata  <= w_if_rdata_nxt;
      r_dm_rdata  <= w_dm_rdata_nxt;
      r_if_ready  <= w_if_ready_nxt;
      r_dm_ready  <= w_dm_ready_nxt;
    end
  end

  assign mem_en    = r_mem_en;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_wstrb = r_mem_wstrb;
  assign if_rdata  = r_if_rdata;
  assign dm_rdata  = r_dm_rdata;
  assign if_ready  = r_if_ready;
  assign dm_ready  = r_dm_ready;
  assign stall_if  = if_req & ~r_if_ready;
  assign stall_mem = dm_req & ~r_dm_ready;
  assign dbg_state = r_state;

endmodule
